// File: rtl/spi_ram_arbiter_pkg.sv
// Shared definitions for the two-port SPI RAM arbiter: FSM encoding, port
// indices and the default read-abort pattern.
package spi_ram_arb_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam logic [31:0] ABORT_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// FemtoRV-style memory port: one-cycle rd/wr strobes with rbusy/wbusy
// back-pressure. The bus master drives the strobes, the arbiter answers.
interface spi_ram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rd;
    logic              wr;
    logic              rbusy;
    logic              wbusy;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, wdata, rd, wr, input rbusy, wbusy, rdata);
    modport slave  (input addr, wdata, rd, wr, output rbusy, wbusy, rdata);
endinterface

// File: rtl/spi_ram_arb_port.sv
// Per-port request capture: pending flags, latched address/write data and
// the read-data holding register.
module spi_ram_arb_port #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               resetn,
    spi_ram_arbiter_if.slave   bus,
    input  logic               clear,
    input  logic               load_rdata,
    input  logic [DATA_W-1:0]  rdata_in,
    output logic               pending_rd,
    output logic               pending_wr,
    output logic [ADDR_W-1:0]  addr_q,
    output logic [DATA_W-1:0]  wdata_q
);

    logic              rd_after_clear;
    logic              wr_after_clear;
    logic              accept;
    logic [DATA_W-1:0] rdata_q;

    // Capture is judged against the flags as they will be after this edge's
    // completion, so a strobe coinciding with the clear is not lost.
    assign rd_after_clear = pending_rd & ~clear;
    assign wr_after_clear = pending_wr & ~clear;
    assign accept         = ~rd_after_clear & ~wr_after_clear & (bus.rd | bus.wr);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_rd <= 1'b0;
            pending_wr <= 1'b0;
            rdata_q    <= '0;
        end else begin
            pending_rd <= accept ? ~bus.wr : rd_after_clear;
            pending_wr <= accept ?  bus.wr : wr_after_clear;
            if (load_rdata) begin
                rdata_q <= rdata_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

    assign bus.rbusy = pending_rd;
    assign bus.wbusy = pending_wr;
    assign bus.rdata = rdata_q;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter and sequencer sharing one MappedSPIRAM between two
// bus masters, with a watchdog that aborts transfers that never complete.
module spi_ram_arbiter
    import spi_ram_arb_defs::*;
#(
    parameter int              ADDR_W     = 20,
    parameter int              DATA_W     = 32,
    parameter int              TIMEOUT    = 4095,
    parameter logic [DATA_W-1:0] ABORT_DATA = DATA_W'(ABORT_DATA_DEFAULT)
) (
    input  logic               clk,
    input  logic               resetn,
    spi_ram_arbiter_if.slave   p0,
    spi_ram_arbiter_if.slave   p1,
    output logic [ADDR_W-1:0]  ram_word_address,
    output logic [DATA_W-1:0]  ram_wdata,
    output logic               ram_rd,
    output logic               ram_wr,
    input  logic               ram_rbusy,
    input  logic               ram_wbusy,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic               grant,
    output logic               timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] TIMEOUT_CNT = WD_W'(TIMEOUT);

    state_t            state_q, state_d;
    logic              grant_d;
    logic              last_grant_q, last_grant_d;
    logic              cur_wr_q, cur_wr_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              ram_rd_d, ram_wr_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_err_d;

    logic [1:0]        clear;
    logic [1:0]        load_rdata;
    logic [DATA_W-1:0] rdata_next;

    logic              p0_pend_rd, p0_pend_wr, p1_pend_rd, p1_pend_wr;
    logic [ADDR_W-1:0] p0_addr_q, p1_addr_q;
    logic [DATA_W-1:0] p0_wdata_q, p1_wdata_q;
    logic [1:0]        req;
    logic              pick;
    logic              pick_wr;
    logic              ram_busy;

    spi_ram_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port0 (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (p0),
        .clear      (clear[PORT_CPU]),
        .load_rdata (load_rdata[PORT_CPU]),
        .rdata_in   (rdata_next),
        .pending_rd (p0_pend_rd),
        .pending_wr (p0_pend_wr),
        .addr_q     (p0_addr_q),
        .wdata_q    (p0_wdata_q)
    );

    spi_ram_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port1 (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (p1),
        .clear      (clear[PORT_AUX]),
        .load_rdata (load_rdata[PORT_AUX]),
        .rdata_in   (rdata_next),
        .pending_rd (p1_pend_rd),
        .pending_wr (p1_pend_wr),
        .addr_q     (p1_addr_q),
        .wdata_q    (p1_wdata_q)
    );

    assign req      = {p1_pend_rd | p1_pend_wr, p0_pend_rd | p0_pend_wr};
    // On a tie the port that was not served last wins.
    assign pick     = (req == 2'b11) ? ~last_grant_q : req[PORT_AUX];
    assign pick_wr  = pick ? p1_pend_wr : p0_pend_wr;
    assign ram_busy = cur_wr_q ? ram_wbusy : ram_rbusy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= IDLE;
            grant            <= PORT_CPU;
            last_grant_q     <= PORT_AUX;
            cur_wr_q         <= 1'b0;
            ram_word_address <= '0;
            ram_wdata        <= '0;
            ram_rd           <= 1'b0;
            ram_wr           <= 1'b0;
            wd_q             <= '0;
            timeout_err      <= 1'b0;
        end else begin
            state_q          <= state_d;
            grant            <= grant_d;
            last_grant_q     <= last_grant_d;
            cur_wr_q         <= cur_wr_d;
            ram_word_address <= addr_d;
            ram_wdata        <= wdata_d;
            ram_rd           <= ram_rd_d;
            ram_wr           <= ram_wr_d;
            wd_q             <= wd_d;
            timeout_err      <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant;
        last_grant_d  = last_grant_q;
        cur_wr_d      = cur_wr_q;
        addr_d        = ram_word_address;
        wdata_d       = ram_wdata;
        ram_rd_d      = 1'b0;
        ram_wr_d      = 1'b0;
        wd_d          = wd_q;
        timeout_err_d = timeout_err;
        clear         = 2'b00;
        load_rdata    = 2'b00;
        rdata_next    = ram_rdata;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d  = pick;
                    addr_d   = pick ? p1_addr_q  : p0_addr_q;
                    wdata_d  = pick ? p1_wdata_q : p0_wdata_q;
                    cur_wr_d = pick_wr;
                    ram_rd_d = ~pick_wr;
                    ram_wr_d = pick_wr;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // wd_q == 0 marks the first WAIT cycle, when downstream busy
                // may not have risen yet.
                if ((wd_q != '0) && !ram_busy) begin
                    clear[grant]      = 1'b1;
                    load_rdata[grant] = ~cur_wr_q;
                    last_grant_d      = grant;
                    state_d           = IDLE;
                end else if (wd_q == TIMEOUT_CNT) begin
                    clear[grant]      = 1'b1;
                    load_rdata[grant] = ~cur_wr_q;
                    rdata_next        = ABORT_DATA;
                    timeout_err_d     = 1'b1;
                    state_d           = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a behavioural MappedSPIRAM model
// whose busy duration (lat) and hang behaviour are set per scenario.
module tb_spi_ram_arbiter;

    localparam int ADDR_W  = 20;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic resetn;

    spi_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p0 ();
    spi_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p1 ();

    logic [ADDR_W-1:0] ram_word_address;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_rd, ram_wr;
    logic              ram_rbusy, ram_wbusy;
    logic              grant, timeout_err;

    int checks = 0;
    int errors = 0;

    spi_ram_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT    (TIMEOUT),
        .ABORT_DATA (32'hDEADBEEF)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .p0               (p0),
        .p1               (p1),
        .ram_word_address (ram_word_address),
        .ram_wdata        (ram_wdata),
        .ram_rd           (ram_rd),
        .ram_wr           (ram_wr),
        .ram_rbusy        (ram_rbusy),
        .ram_wbusy        (ram_wbusy),
        .ram_rdata        (ram_rdata),
        .grant            (grant),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    // Unwritten words read back as a fixed function of their address.
    function automatic logic [31:0] pattern(input logic [19:0] a);
        return 32'h12345668 + {12'h0, a};
    endfunction

    int                lat  = 8;
    bit                hang = 1'b0;
    logic [31:0]       mem     [0:255];
    bit                written [0:255];
    logic [19:0]       raddr;
    int                rcnt, wcnt;
    int                nrd = 0, nwr = 0;
    int                glog[$];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ram_rbusy <= 1'b0;
            ram_wbusy <= 1'b0;
            rcnt      <= 0;
            wcnt      <= 0;
        end else begin
            if (ram_rd) begin
                ram_rbusy <= 1'b1;
                rcnt      <= lat - 1;
                raddr     <= ram_word_address;
            end else if (ram_rbusy && !hang) begin
                if (rcnt == 0) begin
                    ram_rbusy <= 1'b0;
                    ram_rdata <= written[raddr[7:0]] ? mem[raddr[7:0]] : pattern(raddr);
                end else begin
                    rcnt <= rcnt - 1;
                end
            end
            if (ram_wr) begin
                ram_wbusy                     <= 1'b1;
                wcnt                          <= lat - 1;
                mem[ram_word_address[7:0]]     <= ram_wdata;
                written[ram_word_address[7:0]] <= 1'b1;
            end else if (ram_wbusy) begin
                if (wcnt == 0) ram_wbusy <= 1'b0;
                else           wcnt      <= wcnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (resetn) begin
            if (ram_rd) nrd <= nrd + 1;
            if (ram_wr) nwr <= nwr + 1;
            if (ram_rd || ram_wr) glog.push_back(int'(grant));
        end
    end

    task automatic idle_inputs();
        p0.rd = 1'b0; p0.wr = 1'b0; p0.addr = '0; p0.wdata = '0;
        p1.rd = 1'b0; p1.wr = 1'b0; p1.addr = '0; p1.wdata = '0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        hang = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_read(input bit port, input logic [19:0] a,
                           output logic [31:0] d, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        if (port) begin p1.addr = a; p1.rd = 1'b1; end
        else      begin p0.addr = a; p0.rd = 1'b1; end
        @(negedge clk);
        p0.rd = 1'b0;
        p1.rd = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!(port ? p1.rbusy : p0.rbusy)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        d = port ? p1.rdata : p0.rdata;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({p0.rbusy, p0.wbusy, p1.rbusy, p1.wbusy, ram_rd, ram_wr, grant, timeout_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000000",
                     {p0.rbusy, p0.wbusy, p1.rbusy, p1.wbusy, ram_rd, ram_wr, grant, timeout_err});
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if ({ram_word_address, ram_wdata} !== 52'h0) begin
            errors++;
            $display("FAIL reset_ram_bus got %h %h want 0 0", ram_word_address, ram_wdata);
        end
        checks++;
        if ({p0.rdata, p1.rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h %h want 0 0", p0.rdata, p1.rdata);
        end
        checks++;
        if ({p0.rbusy, p1.rbusy, ram_rd, grant, timeout_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_idle got %b want 00000",
                     {p0.rbusy, p1.rbusy, ram_rd, grant, timeout_err});
        end
    endtask

    task automatic test_single_read();
        int r0;
        lat = 8;
        r0  = nrd;
        @(negedge clk);
        p0.addr = 20'h00010;
        p0.rd   = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) p0.rd = 1'b0;
            checks++;
            if (p0.rbusy !== (c <= 11)) begin
                errors++;
                $display("FAIL single_rbusy cycle %0d got %b want %b", c, p0.rbusy, (c <= 11));
            end
            if (c == 2) begin
                checks++;
                if ({ram_rd, ram_word_address} !== {1'b1, 20'h00010}) begin
                    errors++;
                    $display("FAIL single_issue got rd=%b addr=%h want rd=1 addr=00010",
                             ram_rd, ram_word_address);
                end
            end
        end
        checks++;
        if (p0.rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL single_rdata got %h want 12345678", p0.rdata);
        end
        checks++;
        if (nrd - r0 !== 1) begin
            errors++;
            $display("FAIL single_strobes got %0d want 1", nrd - r0);
        end
    endtask

    task automatic test_simultaneous();
        int  g0;
        bit  done;
        reset_dut();
        lat  = 3;
        g0   = glog.size();
        done = 1'b0;
        p0.addr = 20'd5; p0.wdata = 32'hA5A5A5A5; p0.wr = 1'b1;
        p1.addr = 20'd5; p1.rd = 1'b1;
        @(negedge clk);
        p0.wr = 1'b0;
        p1.rd = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!p0.wbusy && !p1.rbusy) begin done = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL simul_done got busy want idle within 200 cycles");
        end
        checks++;
        if (p1.rdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL simul_rdata got %h want a5a5a5a5", p1.rdata);
        end
        checks++;
        if ((glog.size() - g0 != 2) || (glog[g0] != 0) || (glog[g0+1] != 1)) begin
            errors++;
            $display("FAIL simul_grants got count %0d first %0d want count 2 seq 0,1",
                     glog.size() - g0, (glog.size() > g0) ? glog[g0] : -1);
        end
    endtask

    task automatic test_round_robin();
        int g0;
        bit done;
        reset_dut();
        lat  = 2;
        g0   = glog.size();
        done = 1'b0;
        p0.addr = 20'h00040; p0.rd = 1'b1;
        p1.addr = 20'h00041; p1.rd = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (glog.size() - g0 >= 6) break;
        end
        p0.rd = 1'b0;
        p1.rd = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!p0.rbusy && !p1.rbusy) begin done = 1'b1; break; end
        end
        checks++;
        if (!done || (glog.size() - g0 < 6)) begin
            errors++;
            $display("FAIL rr_progress got %0d transfers want at least 6 and drained", glog.size() - g0);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (glog[g0+i] != (i % 2)) begin
                    errors++;
                    $display("FAIL rr_grant %0d got %0d want %0d", i, glog[g0+i], i % 2);
                end
            end
        end
        checks++;
        if ({p0.rdata, p1.rdata} !== {32'h123456A8, 32'h123456A9}) begin
            errors++;
            $display("FAIL rr_rdata got %h %h want 123456a8 123456a9", p0.rdata, p1.rdata);
        end
    endtask

    task automatic test_wr_wins();
        int          r0, w0;
        bit          ok;
        logic [31:0] d;
        lat = 4;
        r0  = nrd;
        w0  = nwr;
        @(negedge clk);
        p0.addr = 20'h00020; p0.wdata = 32'h11112222;
        p0.rd = 1'b1; p0.wr = 1'b1;
        @(negedge clk);
        p0.rd = 1'b0; p0.wr = 1'b0;
        checks++;
        if ({p0.wbusy, p0.rbusy} !== 2'b10) begin
            errors++;
            $display("FAIL wrwin_busy got wbusy=%b rbusy=%b want 1 0", p0.wbusy, p0.rbusy);
        end
        @(negedge clk);
        checks++;
        if ({ram_wr, ram_rd, ram_word_address, ram_wdata} !== {2'b10, 20'h00020, 32'h11112222}) begin
            errors++;
            $display("FAIL wrwin_issue got wr=%b rd=%b addr=%h data=%h want 1 0 00020 11112222",
                     ram_wr, ram_rd, ram_word_address, ram_wdata);
        end
        @(negedge clk);
        p0.addr = 20'h00030; p0.rd = 1'b1;
        @(negedge clk);
        p0.rd = 1'b0;
        checks++;
        if ({p0.rbusy, p0.wbusy} !== 2'b01) begin
            errors++;
            $display("FAIL ignored_strobe got rbusy=%b wbusy=%b want 0 1", p0.rbusy, p0.wbusy);
        end
        for (int i = 0; i < 100; i++) begin
            if (!p0.wbusy) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        checks++;
        if ((nrd - r0 != 0) || (nwr - w0 != 1)) begin
            errors++;
            $display("FAIL wrwin_strobes got rd=%0d wr=%0d want rd=0 wr=1", nrd - r0, nwr - w0);
        end
        do_read(1'b0, 20'h00020, d, ok);
        checks++;
        if (!ok || d !== 32'h11112222) begin
            errors++;
            $display("FAIL wrwin_readback got %h ok=%b want 11112222 ok=1", d, ok);
        end
    endtask

    task automatic test_timeout();
        bit          ok;
        logic [31:0] d;
        lat  = 8;
        hang = 1'b1;
        @(negedge clk);
        p1.addr = 20'h00050; p1.rd = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) p1.rd = 1'b0;
            if (c == 2) begin
                checks++;
                if ({ram_rd, grant} !== 2'b11) begin
                    errors++;
                    $display("FAIL timeout_issue got rd=%b grant=%b want 1 1", ram_rd, grant);
                end
            end
            if (c == 19) begin
                checks++;
                if ({p1.rbusy, timeout_err} !== 2'b10) begin
                    errors++;
                    $display("FAIL timeout_before got rbusy=%b err=%b want 1 0", p1.rbusy, timeout_err);
                end
            end
        end
        checks++;
        if ({p1.rbusy, timeout_err, p1.rdata} !== {2'b01, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL timeout_abort got rbusy=%b err=%b data=%h want 0 1 deadbeef",
                     p1.rbusy, timeout_err, p1.rdata);
        end
        hang = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!ram_rbusy) break;
            @(negedge clk);
        end
        do_read(1'b0, 20'h00060, d, ok);
        checks++;
        if (!ok || d !== 32'h123456C8) begin
            errors++;
            $display("FAIL timeout_recover got %h ok=%b want 123456c8 ok=1", d, ok);
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got %b want 1", timeout_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit          ok;
        logic [31:0] d;
        lat = 8;
        @(negedge clk);
        p0.addr = 20'h00020; p0.rd = 1'b1;
        @(negedge clk);
        p0.rd = 1'b0;
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({p0.rbusy, p0.wbusy, p1.rbusy, p1.wbusy, ram_rd, ram_wr, timeout_err} !== 7'b0) begin
            errors++;
            $display("FAIL midwait_reset got %b want 0000000",
                     {p0.rbusy, p0.wbusy, p1.rbusy, p1.wbusy, ram_rd, ram_wr, timeout_err});
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        do_read(1'b0, 20'h00020, d, ok);
        checks++;
        if (!ok || d !== 32'h11112222) begin
            errors++;
            $display("FAIL midwait_recover got %h ok=%b want 11112222 ok=1", d, ok);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit got running want finished");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_round_robin();
        test_wr_wins();
        test_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the MappedSPIRAM controller. It lets the CPU (port 0) and a second bus master such as a DMA or boot loader (port 1) share the single SPI RAM.
- Each port uses FemtoRV-style one-cycle rd/wr strobes with rbusy/wbusy back-pressure. The block latches requests, grants them round-robin and issues exactly one strobe at a time downstream.
- It waits for the downstream busy signals to clear, then returns read data. A watchdog aborts any transfer that hangs.

Parameters:
- ADDR_W, 20, word-address width (matches mem_address[21:2]).
- DATA_W, 32, data width.
- TIMEOUT, 4095, maximum cycles spent in WAIT before abort; counter width is clog2(TIMEOUT+1).
- ABORT_DATA, 32'hDEADBEEF, rdata returned on a timed-out read.

Ports:
- clk  in  1  system clock (27 MHz).
- resetn  in  1  asynchronous, active-low reset.
- p0_addr  in  ADDR_W  port 0 word address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_rd  in  1  port 0 read strobe (one cycle).
- p0_wr  in  1  port 0 write strobe (one cycle).
- p0_rbusy  out  1  port 0 read pending.
- p0_wbusy  out  1  port 0 write pending.
- p0_rdata  out  DATA_W  port 0 read data, valid when p0_rbusy=0.
- p1_addr, p1_wdata, p1_rd, p1_wr, p1_rbusy, p1_wbusy, p1_rdata: same as port 0, for port 1.
- ram_word_address  out  ADDR_W  to MappedSPIRAM.
- ram_wdata  out  DATA_W  to MappedSPIRAM.
- ram_rd  out  1  downstream read strobe.
- ram_wr  out  1  downstream write strobe.
- ram_rbusy  in  1  from MappedSPIRAM.
- ram_wbusy  in  1  from MappedSPIRAM.
- ram_rdata  in  DATA_W  from MappedSPIRAM.
- grant  out  1  index of the port currently served (debug).
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset values (async on resetn low): all busy outputs 0, ram_rd/ram_wr 0, ram_word_address/ram_wdata 0, p0_rdata/p1_rdata 0, grant 0, timeout_err 0, FSM IDLE, last_grant 1 (so port 0 wins first), pending flags cleared, watchdog 0.
- Reset mid-transfer aborts silently. MappedSPIRAM shares resetn, so no downstream cleanup is needed.
- Request capture, per port:
  - A strobe on an idle port sets pending_rd or pending_wr at the clock edge and latches addr/wdata.
  - pN_rbusy = pending_rd and pN_wbusy = pending_wr, both registered; busy is therefore high the cycle after the strobe.
  - If rd and wr arrive in the same cycle, wr wins and rd is dropped.
  - A strobe on a port that already has a request pending is ignored; the latched request is not overwritten.
- FSM states and transitions:
  - IDLE: if any port is pending, pick one round-robin (the port other than last_grant wins on a tie), load ram_word_address/ram_wdata and grant, then go to ISSUE.
  - ISSUE: exactly one cycle. ram_rd or ram_wr = 1 (registered), watchdog cleared. Go to WAIT.
  - WAIT: ram_rd/ram_wr = 0 and the watchdog increments.
    - If the relevant ram busy is 0 (ram_rbusy for reads, ram_wbusy for writes): capture ram_rdata into pN_rdata (reads only), clear the pending flag, set last_grant=grant, go to IDLE.
    - Else if watchdog == TIMEOUT: pN_rdata = ABORT_DATA (reads only), clear pending, set timeout_err, go to IDLE.
- Downstream contract: MappedSPIRAM asserts busy no later than the cycle after the strobe. WAIT therefore ignores busy during its first cycle and samples it from the second WAIT cycle onward.
- Latency: strobe at cycle 0 → busy high at cycle 1 → ram strobe at cycle 2. A completion detected at cycle N gives port busy low with rdata valid at cycle N+1. Minimum read latency is 5 cycles.
- pN_rdata holds its value until that port's next read completes. Writes never modify rdata.
- A new strobe may arrive in the same cycle the port's busy falls. The request is accepted because the pending flag clears at that edge and capture is evaluated after the clear.
- timeout_err is cleared only by reset.
- Throughput: one transfer at a time; IDLE always costs at least one cycle between transfers.

Decomposition:
- Shared package/include spi_ram_arb_defs:
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2.
  - Port indices PORT_CPU=0, PORT_AUX=1.
  - ABORT_DATA default value.
- One sub-module: spi_ram_arb_port. It holds one port's capture logic (pending flags, latched addr/wdata, rdata register) and is instantiated twice.
- The FSM, round-robin logic and watchdog stay in the top.

Test Plan:
- Single read: p0_rd at addr 20'h00010; model returns 32'h12345678 after 8 busy cycles → ram_rd pulses once at cycle 2; p0_rbusy high cycles 1..N; p0_rdata=32'h12345678 when p0_rbusy drops.
- Simultaneous requests after reset: p0_wr(addr 5, data 32'hA5A5A5A5) and p1_rd(addr 5) in the same cycle → port 0 write served first, then port 1 read returns 32'hA5A5A5A5; grant sequence 0,1.
- Round-robin fairness: both ports strobe continuously for 6 transfers → grant alternates 0,1,0,1,0,1; no port waits more than one transfer.
- Timeout: model holds ram_rbusy=1 forever with TIMEOUT=16 → p1_rdata=32'hDEADBEEF 18 cycles after ISSUE; timeout_err=1 and stays 1; a following p0 read completes normally.
- Ignored strobe and wr-wins: p0_rd and p0_wr in the same cycle → only ram_wr issued. A second p0_rd while p0_wbusy=1 → ignored, exactly one ram strobe total.
- Reset mid-WAIT: resetn low during WAIT → all busy outputs, ram_rd/ram_wr and timeout_err are 0 immediately (asynchronously). After release, a fresh p0 read completes with correct data.
